softmax_stream: RTL and testbench
=================================

Name: softmax_stream

Overview:
Element-serial, handshaked fixed-point softmax. Successor to the vector-parallel base-2 softmax, with runtime vector length, a fractional exp2 approximation, a sequential exact divider, and valid/ready backpressure on both sides. It sits between an attention-score producer and the weighting stage in the transformer datapath. It processes one vector at a time: load, then exponentiate, then normalise and stream out.

Parameters:
N, 64, maximum vector length (>=1)
IN_W, 16, signed input width, two's complement
FRAC, 8, input fraction bits (IN_W=16, FRAC=8 gives Q8.8)
EXP_FB, 15, fraction bits of exp value; exp(0) = 1<<EXP_FB
OUT_W, 16, unsigned output width, format Q1.(OUT_W-1)

Ports:
clk  in  1  clock, all logic on rising edge
rst  in  1  synchronous, active-high reset
cfg_len  in  clog2(N+1)  vector length 1..N; sampled on the first accepted element of a vector
in_valid  in  1  input element valid
in_ready  out  1  block can accept an element
in_data  in  IN_W  signed score
out_valid  out  1  output element valid
out_ready  in  1  consumer accepts an element
out_data  out  OUT_W  softmax probability
out_last  out  1  marks the final element of the vector
busy  out  1  high in every state except S_LOAD with zero elements loaded

Behaviour:
- Reset values: in_ready=1, out_valid=0, out_data=0, out_last=0, busy=0. State=S_LOAD, count=0, max=most-negative value.
- Reset mid-operation: the current vector is discarded and no partial output is emitted. rst takes priority over every handshake in that cycle.
- S_LOAD: in_ready=1. Each handshake writes in_data to buf[idx] and updates the running max with a signed compare.
  - len = cfg_len is latched on idx=0. cfg_len=0 or cfg_len>N is clamped to 1 or N respectively.
  - When the handshake with idx=len-1 occurs, go to S_EXP next cycle. in_ready drops that cycle.
- S_EXP: one element per cycle, len cycles.
  - d = max - buf[i], unsigned, always >=0; k = d>>FRAC; f = d[FRAC-1:0].
  - e = ((1<<EXP_FB) - (f << (EXP_FB-FRAC-1))) >> min(k, EXP_FB+1). This is the linear 2^-f ≈ 1 - f/2.
  - e overwrites buf[i] (buffer width max(IN_W, EXP_FB+1)). sum += e.
  - sum width = EXP_FB+1+clog2(N), no overflow possible. sum>0 is guaranteed because the max element gives e = 1<<EXP_FB.
- S_DIV: restoring divider, exactly OUT_W cycles per element.
  - q = floor((buf[i] << (OUT_W-1)) / sum). No rounding. q <= 1<<(OUT_W-1), so no saturation is needed.
- S_OUT: out_valid=1, out_data=q, out_last=(i==len-1). Outputs are held stable until out_ready.
  - On handshake: if not last, i++ and go to S_DIV. If last, go to S_LOAD, clear count and max.
  - out_ready high before out_valid has no effect.
- Throughput: no overlap between vectors. in_ready=0 from the final input handshake until the cycle after the final output handshake.
- Latency, final input handshake to first out_valid: len + OUT_W + 1 cycles.
- Per subsequent element, with out_ready held high: OUT_W + 1 cycles.
- Output order equals input order. Inputs that are equal within the same vector give bit-identical outputs.

Test Plan:
- len=4, all inputs 0x0100 -> each e=32768, sum=131072, outputs 8192,8192,8192,8192, out_last on 4th only.
- len=2, inputs {0x0100, 0x0000} -> e={32768,16384}, sum=49152, outputs {21845, 10922}.
- len=2, inputs {0x0000, 0xFF80} (d=0x80) -> e={32768,24576}, outputs {18724, 14043}.
- len=1, input 0x8000 -> output 32768, out_last=1. Also len=3 with inputs {0x7FFF,0x8000,0x8000} -> d>>8 = 255 > 16 gives e=0, outputs {32768,0,0}.
- Backpressure: len=4, out_ready toggled randomly -> out_data/out_last stay stable while out_valid && !out_ready. Each value is emitted exactly once, in_ready=0 throughout, and the next vector is accepted only after the last handshake.
- Reset: assert rst for 1 cycle during S_DIV of element 2 -> next cycle out_valid=0, in_ready=1, busy=0. A following len=4 all-equal vector yields 8192 x4 with no stale output.

Source files
------------

// File: rtl/softmax_stream.sv
// Element-serial fixed-point softmax: load a vector, apply a base-2 exp approximation, then
// normalise each element with a restoring divider and stream it out under valid/ready handshakes.
module softmax_stream #(
    parameter int N      = 64,
    parameter int IN_W   = 16,
    parameter int FRAC   = 8,
    parameter int EXP_FB = 15,
    parameter int OUT_W  = 16
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [$clog2(N+1)-1:0]     cfg_len,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic signed [IN_W-1:0]     in_data,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [OUT_W-1:0]           out_data,
    output logic                       out_last,
    output logic                       busy
);

    localparam int unsigned LEN_W = $clog2(N + 1);
    localparam int unsigned IDX_W = (N > 1) ? $clog2(N) : 1;
    localparam int unsigned EXP_W = EXP_FB + 1;
    localparam int unsigned BUF_W = (IN_W > EXP_W) ? IN_W : EXP_W;
    localparam int unsigned SUM_W = EXP_FB + 1 + ((N > 1) ? $clog2(N) : 0);
    localparam int unsigned CNT_W = $clog2(OUT_W + 1);
    localparam int unsigned F_SH  = EXP_FB - FRAC - 1;

    localparam logic signed [IN_W-1:0] MAX_INIT = {1'b1, {(IN_W-1){1'b0}}};
    localparam logic [EXP_W-1:0]       E_ONE    = {1'b1, {EXP_FB{1'b0}}};

    typedef enum logic [1:0] {S_LOAD, S_EXP, S_DIV, S_OUT} state_t;

    state_t                   state;
    logic [BUF_W-1:0]         buf_mem [N];
    logic [LEN_W-1:0]         idx;
    logic [LEN_W-1:0]         len_q;
    logic signed [IN_W-1:0]   max_q;
    logic [SUM_W-1:0]         sum_q;
    logic [CNT_W-1:0]         cnt;
    logic [SUM_W-1:0]         rem;
    logic [OUT_W-1:0]         lo;

    logic [IDX_W-1:0]         addr;
    logic [LEN_W-1:0]         len_in_c;
    logic [LEN_W-1:0]         len_cur_c;
    logic                     last_load_c;
    logic                     in_hs_c;
    logic signed [IN_W-1:0]   elem_c;
    logic [IN_W-1:0]          d_c;
    logic [IN_W-FRAC-1:0]     k_c;
    logic [FRAC-1:0]          f_c;
    logic [EXP_W-1:0]         base_c;
    logic [EXP_W-1:0]         e_c;
    logic [EXP_W-1:0]         ev_c;
    logic [SUM_W:0]           t_c;
    logic                     ge_c;
    logic [SUM_W-1:0]         rem_n_c;

    assign addr    = idx[IDX_W-1:0];
    assign in_hs_c = in_valid && in_ready;

    // Clamp the requested length into 1..N; it only counts on the first element of a vector.
    always_comb begin
        len_in_c = cfg_len;
        if (cfg_len == '0) begin
            len_in_c = LEN_W'(1);
        end else if (cfg_len > LEN_W'(N)) begin
            len_in_c = LEN_W'(N);
        end
    end

    assign len_cur_c   = (idx == '0) ? len_in_c : len_q;
    assign last_load_c = (idx == len_cur_c - LEN_W'(1));

    // Linear 2^-x approximation: integer part is a shift, fraction f gives 1 - f/2.
    assign elem_c = buf_mem[addr][IN_W-1:0];
    assign d_c    = IN_W'(max_q - elem_c);
    assign k_c    = d_c[IN_W-1:FRAC];
    assign f_c    = d_c[FRAC-1:0];
    assign base_c = E_ONE - (EXP_W'(f_c) << F_SH);
    assign e_c    = (k_c > (IN_W-FRAC)'(EXP_FB)) ? '0 : (base_c >> k_c);

    // One restoring-division step; lo shifts dividend bits out and quotient bits in.
    assign ev_c    = buf_mem[addr][EXP_W-1:0];
    assign t_c     = {rem, lo[OUT_W-1]};
    assign ge_c    = (t_c >= {1'b0, sum_q});
    assign rem_n_c = ge_c ? SUM_W'(t_c - {1'b0, sum_q}) : SUM_W'(t_c);

    always_ff @(posedge clk) begin
        if (!rst) begin
            if (state == S_LOAD && in_hs_c) begin
                buf_mem[addr] <= BUF_W'(in_data);
            end else if (state == S_EXP) begin
                buf_mem[addr] <= BUF_W'(e_c);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= S_LOAD;
            idx       <= '0;
            len_q     <= LEN_W'(1);
            max_q     <= MAX_INIT;
            sum_q     <= '0;
            cnt       <= '0;
            rem       <= '0;
            lo        <= '0;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
            out_data  <= '0;
            out_last  <= 1'b0;
            busy      <= 1'b0;
        end else begin
            case (state)
                S_LOAD: begin
                    if (in_hs_c) begin
                        busy <= 1'b1;
                        if (idx == '0) begin
                            len_q <= len_in_c;
                        end
                        if (in_data > max_q) begin
                            max_q <= in_data;
                        end
                        if (last_load_c) begin
                            in_ready <= 1'b0;
                            idx      <= '0;
                            sum_q    <= '0;
                            state    <= S_EXP;
                        end else begin
                            idx <= idx + LEN_W'(1);
                        end
                    end
                end
                S_EXP: begin
                    sum_q <= sum_q + SUM_W'(e_c);
                    if (idx == len_q - LEN_W'(1)) begin
                        idx   <= '0;
                        cnt   <= '0;
                        state <= S_DIV;
                    end else begin
                        idx <= idx + LEN_W'(1);
                    end
                end
                S_DIV: begin
                    if (cnt == '0) begin
                        rem <= SUM_W'(ev_c >> 1);
                        lo  <= {ev_c[0], {(OUT_W-1){1'b0}}};
                        cnt <= CNT_W'(1);
                    end else begin
                        rem <= rem_n_c;
                        lo  <= {lo[OUT_W-2:0], ge_c};
                        if (cnt == CNT_W'(OUT_W)) begin
                            out_data  <= {lo[OUT_W-2:0], ge_c};
                            out_valid <= 1'b1;
                            out_last  <= (idx == len_q - LEN_W'(1));
                            state     <= S_OUT;
                        end else begin
                            cnt <= cnt + CNT_W'(1);
                        end
                    end
                end
                S_OUT: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        out_last  <= 1'b0;
                        if (out_last) begin
                            idx      <= '0;
                            max_q    <= MAX_INIT;
                            in_ready <= 1'b1;
                            busy     <= 1'b0;
                            state    <= S_LOAD;
                        end else begin
                            idx   <= idx + LEN_W'(1);
                            cnt   <= '0;
                            state <= S_DIV;
                        end
                    end
                end
                default: state <= S_LOAD;
            endcase
        end
    end

endmodule

// File: tb/tb_softmax_stream.sv
// Directed bench for softmax_stream: hand-computed vectors, latency, backpressure hold and mid-vector reset.
module tb_softmax_stream;

    localparam int N     = 64;
    localparam int IN_W  = 16;
    localparam int OUT_W = 16;
    localparam int LEN_W = 7;

    logic                    clk = 1'b0;
    logic                    rst;
    logic [LEN_W-1:0]        cfg_len;
    logic                    in_valid;
    logic                    in_ready;
    logic signed [IN_W-1:0]  in_data;
    logic                    out_valid;
    logic                    out_ready;
    logic [OUT_W-1:0]        out_data;
    logic                    out_last;
    logic                    busy;

    int checks   = 0;
    int failures = 0;

    logic [15:0] vin  [8];
    int          vexp [8];

    softmax_stream #(.N(N), .IN_W(IN_W), .FRAC(8), .EXP_FB(15), .OUT_W(OUT_W)) dut (
        .clk       (clk),
        .rst       (rst),
        .cfg_len   (cfg_len),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_last  (out_last),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input longint got, input longint exp);
        checks++;
        if (got != exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Feed n elements with cfg_len = cfg; returns at the negedge after the final handshake.
    task automatic send(input int cfg, input int n);
        int w;
        for (int i = 0; i < n; i++) begin
            in_valid = 1'b1;
            in_data  = vin[i];
            cfg_len  = LEN_W'(cfg);
            w = 0;
            while (!in_ready && w < 300) begin
                @(negedge clk);
                w++;
            end
            if (w >= 300) begin
                chk("in_timeout", 0, 1);
                in_valid = 1'b0;
                return;
            end
            @(negedge clk);
        end
        in_valid = 1'b0;
        chk("in_ready_drop", in_ready, 0);
    endtask

    // Collect `take` outputs of a len-element vector; mode 0 = ready held high, 1 = random ready.
    task automatic recv(input int take, input int len, input int mode);
        int          lat;
        int          guard;
        bit          seen;
        bit          done;
        bit          r;
        logic [15:0] held;
        logic        held_last;
        for (int j = 0; j < take; j++) begin
            if (mode == 0) out_ready = 1'b1;
            lat = 0; guard = 0; seen = 0; done = 0;
            held = '0; held_last = 1'b0;
            while (!done && guard < 600) begin
                guard++;
                if (out_valid) begin
                    if (!seen) begin
                        seen      = 1;
                        held      = out_data;
                        held_last = out_last;
                        chk($sformatf("data[%0d]", j), out_data, vexp[j]);
                        chk($sformatf("last[%0d]", j), out_last, (j == len - 1) ? 1 : 0);
                        chk("in_ready_busy", in_ready, 0);
                        if (mode == 0) begin
                            chk($sformatf("latency[%0d]", j), lat,
                                (j == 0) ? len + OUT_W + 1 : OUT_W + 1);
                        end
                    end else begin
                        chk("hold_data", out_data, held);
                        chk("hold_last", out_last, held_last);
                    end
                    r = (mode == 0) ? 1'b1 : 1'($urandom_range(0, 1));
                    out_ready = r;
                    @(negedge clk);
                    if (r) done = 1;
                end else begin
                    if (mode != 0) out_ready = 1'($urandom_range(0, 1));
                    @(negedge clk);
                    lat++;
                end
            end
            if (!done) chk("out_timeout", 0, 1);
        end
        out_ready = 1'b0;
        if (take == len) begin
            chk("in_ready_after", in_ready, 1);
            chk("busy_after", busy, 0);
            chk("valid_after", out_valid, 0);
        end
    endtask

    initial begin
        int stale;
        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; cfg_len = '0; in_data = '0;
        repeat (3) @(negedge clk);
        chk("rst_in_ready", in_ready, 1);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_out_data", out_data, 0);
        chk("rst_out_last", out_last, 0);
        chk("rst_busy", busy, 0);
        rst = 1'b0;
        @(negedge clk);

        // Four equal scores.
        vin  = '{16'h0100, 16'h0100, 16'h0100, 16'h0100, 16'h0, 16'h0, 16'h0, 16'h0};
        vexp = '{8192, 8192, 8192, 8192, 0, 0, 0, 0};
        send(4, 4); recv(4, 4, 0);

        // Integer step of one: halving.
        vin  = '{16'h0100, 16'h0000, 16'h0, 16'h0, 16'h0, 16'h0, 16'h0, 16'h0};
        vexp = '{21845, 10922, 0, 0, 0, 0, 0, 0};
        send(2, 2); recv(2, 2, 0);

        // Fractional step of one half.
        vin  = '{16'h0000, 16'hFF80, 16'h0, 16'h0, 16'h0, 16'h0, 16'h0, 16'h0};
        vexp = '{18724, 14043, 0, 0, 0, 0, 0, 0};
        send(2, 2); recv(2, 2, 0);

        // Single most-negative element.
        vin  = '{16'h8000, 16'h0, 16'h0, 16'h0, 16'h0, 16'h0, 16'h0, 16'h0};
        vexp = '{32768, 0, 0, 0, 0, 0, 0, 0};
        send(1, 1); recv(1, 1, 0);

        // Full-range spread underflows to zero.
        vin  = '{16'h7FFF, 16'h8000, 16'h8000, 16'h0, 16'h0, 16'h0, 16'h0, 16'h0};
        vexp = '{32768, 0, 0, 0, 0, 0, 0, 0};
        send(3, 3); recv(3, 3, 0);

        // cfg_len of zero clamps to one.
        vin  = '{16'h1234, 16'h0, 16'h0, 16'h0, 16'h0, 16'h0, 16'h0, 16'h0};
        vexp = '{32768, 0, 0, 0, 0, 0, 0, 0};
        send(0, 1); recv(1, 1, 0);

        // Mixed vector under random backpressure: e = {32768,16384,12288,32768}, sum 94208.
        vin  = '{16'h0100, 16'h0000, 16'hFF80, 16'h0100, 16'h0, 16'h0, 16'h0, 16'h0};
        vexp = '{11397, 5698, 4274, 11397, 0, 0, 0, 0};
        send(4, 4); recv(4, 4, 1);

        // Reset while element 2 is in the divider.
        vin  = '{16'h0100, 16'h0100, 16'h0100, 16'h0100, 16'h0, 16'h0, 16'h0, 16'h0};
        vexp = '{8192, 8192, 8192, 8192, 0, 0, 0, 0};
        send(4, 4); recv(2, 4, 0);
        repeat (5) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("mid_rst_valid", out_valid, 0);
        chk("mid_rst_in_ready", in_ready, 1);
        chk("mid_rst_busy", busy, 0);
        out_ready = 1'b1;
        stale = 0;
        repeat (40) begin
            @(negedge clk);
            if (out_valid) stale++;
        end
        out_ready = 1'b0;
        chk("no_stale_output", stale, 0);

        send(4, 4); recv(4, 4, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
